// File: rtl/qsys_design_onchip_ram_2port.sv
// Dual-port on-chip RAM with byte enables, clock-enabled read pipelines,
// sticky out-of-range flag and a saturating same-address write collision counter.
module qsys_design_onchip_ram_2port #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int DEPTH        = 10120,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic                    s1_clken,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic                    s2_clken,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    oob_err,
    output logic [15:0]             collision_count
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [NB-1:0]         be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    logic [1:0] ce;
    logic [1:0] acc;
    logic [1:0] rd_acc;
    logic [1:0] wr_acc;
    logic [1:0] in_rng;
    logic [1:0] wr_ok;
    logic       collide;
    logic       oob_hit;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;

    // A simultaneous read+write on one port is treated as a write only
    assign ce      = {s2_clken, s1_clken};
    assign acc     = ce & {s2_chipselect, s1_chipselect};
    assign wr_acc  = acc & {s2_write, s1_write};
    assign rd_acc  = acc & {s2_read & ~s2_write, s1_read & ~s1_write};
    assign in_rng  = {({1'b0, s2_address} < DEPTH_LIM), ({1'b0, s1_address} < DEPTH_LIM)};
    assign wr_ok   = wr_acc & in_rng;
    assign collide = wr_ok[0] & wr_ok[1] & (s1_address == s2_address);
    assign oob_hit = |(acc & {s2_read | s2_write, s1_read | s1_write} & ~in_rng);

    // On a same-address collision s1 owns every lane it enables; s2 fills the rest
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_ok[0] && be[0][b])
                mem[addr[0]][b*8 +: 8] <= wdata[0][b*8 +: 8];
            if (wr_ok[1] && be[1][b] && !(collide && be[0][b]))
                mem[addr[1]][b*8 +: 8] <= wdata[1][b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oob_err         <= 1'b0;
            collision_count <= '0;
        end else begin
            if (oob_hit)
                oob_err <= 1'b1;
            if (collide)
                collision_count <= sat_inc16(collision_count);
        end
    end

    logic [1:0][DATA_WIDTH-1:0] rdata_all;
    logic [1:0]                 rvld_all;

    for (genvar n = 0; n < 2; n++) begin : g_port
        logic [DATA_WIDTH-1:0] rd_word;

        // Out-of-range reads still complete, returning zero
        assign rd_word = in_rng[n] ? mem[addr[n]] : '0;

        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] data_p1;
            logic [DATA_WIDTH-1:0] data_p2;
            logic                  vld_p1;
            logic                  vld_p2;

            // Stage p1: registered array output
            always_ff @(posedge clk) begin
                if (rd_acc[n])
                    data_p1 <= rd_word;
            end

            // Stage p2: registered readdata; a stalled edge emits no beat
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_p1  <= 1'b0;
                    vld_p2  <= 1'b0;
                    data_p2 <= '0;
                end else if (ce[n]) begin
                    vld_p1 <= rd_acc[n];
                    vld_p2 <= vld_p1;
                    if (vld_p1)
                        data_p2 <= data_p1;
                end else begin
                    vld_p2 <= 1'b0;
                end
            end

            assign rdata_all[n] = data_p2;
            assign rvld_all[n]  = vld_p2;
        end else begin : g_lat1
            logic [DATA_WIDTH-1:0] data_p1;
            logic                  vld_p1;

            // Stage p1: registered readdata, held between beats
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_p1  <= 1'b0;
                    data_p1 <= '0;
                end else if (ce[n]) begin
                    vld_p1 <= rd_acc[n];
                    if (rd_acc[n])
                        data_p1 <= rd_word;
                end else begin
                    vld_p1 <= 1'b0;
                end
            end

            assign rdata_all[n] = data_p1;
            assign rvld_all[n]  = vld_p1;
        end
    end

    assign s1_readdata      = rdata_all[0];
    assign s2_readdata      = rdata_all[1];
    assign s1_readdatavalid = rvld_all[0];
    assign s2_readdatavalid = rvld_all[1];

endmodule

// File: tb/tb_qsys_design_onchip_ram_2port.sv
// Bench for qsys_design_onchip_ram_2port: latency-1 and latency-2 instances share
// one stimulus stream and are checked against a transaction-level memory model.
module tb_qsys_design_onchip_ram_2port;

    localparam int DW    = 32;
    localparam int AW    = 14;
    localparam int DEPTH = 10120;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write, s1_clken;
    logic          s2_chipselect, s2_read, s2_write, s2_clken;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata;

    logic [DW-1:0] d1_s1_readdata, d1_s2_readdata, d2_s1_readdata, d2_s2_readdata;
    logic          d1_s1_readdatavalid, d1_s2_readdatavalid, d2_s1_readdatavalid, d2_s2_readdatavalid;
    logic          d1_oob, d2_oob;
    logic [15:0]   d1_coll, d2_coll;

    always #5 clk = ~clk;

    qsys_design_onchip_ram_2port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_clken(s1_clken), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(d1_s1_readdata), .s1_readdatavalid(d1_s1_readdatavalid),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_clken(s2_clken), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(d1_s2_readdata), .s2_readdatavalid(d1_s2_readdatavalid),
        .oob_err(d1_oob), .collision_count(d1_coll)
    );

    qsys_design_onchip_ram_2port #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .reset_n(reset_n),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_clken(s1_clken), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(d2_s1_readdata), .s1_readdatavalid(d2_s1_readdatavalid),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_clken(s2_clken), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(d2_s2_readdata), .s2_readdatavalid(d2_s2_readdatavalid),
        .oob_err(d2_oob), .collision_count(d2_coll)
    );

    // Index k = instance*2 + port: 0/1 latency-1 s1/s2, 2/3 latency-2 s1/s2
    logic [DW-1:0] act_data [4];
    logic          act_vld  [4];
    assign act_data[0] = d1_s1_readdata;  assign act_vld[0] = d1_s1_readdatavalid;
    assign act_data[1] = d1_s2_readdata;  assign act_vld[1] = d1_s2_readdatavalid;
    assign act_data[2] = d2_s1_readdata;  assign act_vld[2] = d2_s1_readdatavalid;
    assign act_data[3] = d2_s2_readdata;  assign act_vld[3] = d2_s2_readdatavalid;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: sparse word store plus per-output queues of outstanding reads
    logic [DW-1:0] mmem [int];
    int            pcnt [4][$];
    logic [DW-1:0] pdat [4][$];
    logic [DW-1:0] exp_data [4];
    bit            exp_vld  [4];
    bit            m_oob;
    int            m_coll;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            pcnt[k].delete();
            pdat[k].delete();
            exp_vld[k]  = 1'b0;
            exp_data[k] = '0;
        end
        m_oob  = 1'b0;
        m_coll = 0;
    endtask

    task automatic idle();
        s1_address = '0; s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s1_clken = 1'b1; s1_byteenable = '0; s1_writedata = '0;
        s2_address = '0; s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
        s2_clken = 1'b1; s2_byteenable = '0; s2_writedata = '0;
    endtask

    task automatic drive(input int p, input bit rd, input bit wr, input int addr,
                         input logic [3:0] be, input logic [DW-1:0] wd);
        if (p == 1) begin
            s1_address = AW'(addr); s1_chipselect = 1'b1; s1_read = rd; s1_write = wr;
            s1_clken = 1'b1; s1_byteenable = be; s1_writedata = wd;
        end else begin
            s2_address = AW'(addr); s2_chipselect = 1'b1; s2_read = rd; s2_write = wr;
            s2_clken = 1'b1; s2_byteenable = be; s2_writedata = wd;
        end
    endtask

    // Apply the current inputs to the model, then advance one clock
    task automatic step();
        int            a [2];
        bit            cs [2], ce [2], rds [2], wrs [2];
        bit            rd [2], wr [2], inr [2], acc [2];
        logic [3:0]    be [2];
        logic [DW-1:0] wd [2], rv [2], w;
        int            p, lat;
        a[0] = int'(s1_address); cs[0] = s1_chipselect; ce[0] = s1_clken; rds[0] = s1_read;
        wrs[0] = s1_write; be[0] = s1_byteenable; wd[0] = s1_writedata;
        a[1] = int'(s2_address); cs[1] = s2_chipselect; ce[1] = s2_clken; rds[1] = s2_read;
        wrs[1] = s2_write; be[1] = s2_byteenable; wd[1] = s2_writedata;
        if (reset_n) begin
            for (int q = 0; q < 2; q++) begin
                acc[q] = cs[q] && ce[q];
                wr[q]  = acc[q] && wrs[q];
                rd[q]  = acc[q] && rds[q] && !wrs[q];
                inr[q] = a[q] < DEPTH;
                if (acc[q] && (rds[q] || wrs[q]) && !inr[q]) m_oob = 1'b1;
                if (!inr[q]) rv[q] = '0;
                else if (mmem.exists(a[q])) rv[q] = mmem[a[q]];
                else rv[q] = 'x;
            end
            for (int k = 0; k < 4; k++) begin
                p = k % 2;
                lat = k / 2 + 1;
                exp_vld[k] = 1'b0;
                if (ce[p])
                    for (int i = 0; i < pcnt[k].size(); i++) pcnt[k][i] = pcnt[k][i] - 1;
                if (rd[p]) begin
                    pcnt[k].push_back(lat - 1);
                    pdat[k].push_back(rv[p]);
                end
                if (ce[p] && pcnt[k].size() != 0 && pcnt[k][0] == 0) begin
                    exp_vld[k]  = 1'b1;
                    exp_data[k] = pdat[k].pop_front();
                    void'(pcnt[k].pop_front());
                end
            end
            if (wr[0] && wr[1] && inr[0] && a[0] == a[1] && m_coll < 65535) m_coll++;
            // s2 applied first so s1 lanes take precedence
            for (int q = 1; q >= 0; q--) begin
                if (wr[q] && inr[q]) begin
                    w = mmem.exists(a[q]) ? mmem[a[q]] : 'x;
                    for (int b = 0; b < 4; b++)
                        if (be[q][b]) w[b*8 +: 8] = wd[q][b*8 +: 8];
                    mmem[a[q]] = w;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (act_vld[k] !== 1'b0) begin
                miscompares++; $display("FAIL reset_vld[%0d]: got %b want 0", k, act_vld[k]);
            end
            vectors++;
            if (act_data[k] !== 32'h0) begin
                miscompares++; $display("FAIL reset_data[%0d]: got %h want 0", k, act_data[k]);
            end
        end
        vectors++;
        if (d1_oob !== 1'b0 || d2_oob !== 1'b0) begin
            miscompares++; $display("FAIL reset_oob: got %b/%b want 0/0", d1_oob, d2_oob);
        end
        vectors++;
        if (d1_coll !== 16'h0 || d2_coll !== 16'h0) begin
            miscompares++; $display("FAIL reset_coll: got %h/%h want 0/0", d1_coll, d2_coll);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk); idle(); drive(1, 0, 1, 5, 4'hF, 32'hDEADBEEF); step();
        @(negedge clk); idle(); drive(2, 1, 0, 5, 4'h0, 32'h0); step();
        vectors++;
        if (d1_s2_readdatavalid !== 1'b1 || d1_s2_readdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_rd_lat1: got vld=%b data=%h want vld=1 data=deadbeef", d1_s2_readdatavalid, d1_s2_readdata);
        end
        vectors++;
        if (d2_s2_readdatavalid !== 1'b0) begin
            miscompares++; $display("FAIL wr_rd_lat2_early: got vld=%b want 0", d2_s2_readdatavalid);
        end
        @(negedge clk); idle(); step();
        vectors++;
        if (d1_s2_readdatavalid !== 1'b0 || d1_s2_readdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_rd_hold: got vld=%b data=%h want vld=0 data=deadbeef", d1_s2_readdatavalid, d1_s2_readdata);
        end
        vectors++;
        if (d2_s2_readdatavalid !== 1'b1 || d2_s2_readdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL wr_rd_lat2: got vld=%b data=%h want vld=1 data=deadbeef", d2_s2_readdatavalid, d2_s2_readdata);
        end
    endtask

    task automatic test_byte_lanes();
        @(negedge clk); idle(); drive(1, 0, 1, 7, 4'hF, 32'h11223344); step();
        @(negedge clk); idle(); drive(1, 0, 1, 7, 4'b0101, 32'hAABBCCDD); step();
        @(negedge clk); idle(); drive(1, 1, 0, 7, 4'h0, 32'h0); step();
        vectors++;
        if (d1_s1_readdatavalid !== 1'b1 || d1_s1_readdata !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL byte_lanes: got vld=%b data=%h want vld=1 data=11bb33dd", d1_s1_readdatavalid, d1_s1_readdata);
        end
        @(negedge clk); idle(); step();
        vectors++;
        if (d2_s1_readdatavalid !== 1'b1 || d2_s1_readdata !== 32'h11BB33DD) begin
            miscompares++;
            $display("FAIL byte_lanes_lat2: got vld=%b data=%h want vld=1 data=11bb33dd", d2_s1_readdatavalid, d2_s1_readdata);
        end
    endtask

    task automatic test_collision();
        @(negedge clk); idle(); drive(1, 0, 1, 9, 4'hF, 32'h0); step();
        @(negedge clk); idle();
        drive(1, 0, 1, 9, 4'b0001, 32'h000000AA);
        drive(2, 0, 1, 9, 4'b0011, 32'hBBBBBBBB);
        step();
        vectors++;
        if (d1_coll !== 16'd1 || d2_coll !== 16'd1) begin
            miscompares++; $display("FAIL collision_count: got %0d/%0d want 1/1", d1_coll, d2_coll);
        end
        @(negedge clk); idle(); drive(2, 1, 0, 9, 4'h0, 32'h0); step();
        vectors++;
        if (d1_s2_readdatavalid !== 1'b1 || d1_s2_readdata !== 32'h0000BBAA) begin
            miscompares++;
            $display("FAIL collision_data: got vld=%b data=%h want vld=1 data=0000bbaa", d1_s2_readdatavalid, d1_s2_readdata);
        end
    endtask

    task automatic test_oob();
        vectors++;
        if (d1_oob !== 1'b0) begin
            miscompares++; $display("FAIL oob_initial: got %b want 0", d1_oob);
        end
        @(negedge clk); idle(); drive(1, 1, 0, DEPTH, 4'h0, 32'h0); step();
        vectors++;
        if (d1_s1_readdatavalid !== 1'b1 || d1_s1_readdata !== 32'h0 || d1_oob !== 1'b1) begin
            miscompares++;
            $display("FAIL oob_read: got vld=%b data=%h oob=%b want vld=1 data=0 oob=1", d1_s1_readdatavalid, d1_s1_readdata, d1_oob);
        end
        @(negedge clk); idle(); step();
        vectors++;
        if (d2_s1_readdatavalid !== 1'b1 || d2_s1_readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL oob_read_lat2: got vld=%b data=%h want vld=1 data=0", d2_s1_readdatavalid, d2_s1_readdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); step();
        end
        vectors++;
        if (d1_oob !== 1'b1 || d2_oob !== 1'b1) begin
            miscompares++; $display("FAIL oob_sticky: got %b/%b want 1/1", d1_oob, d2_oob);
        end
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (d1_oob !== 1'b0 || d2_oob !== 1'b0 || d1_coll !== 16'h0) begin
            miscompares++; $display("FAIL oob_reset: got oob=%b/%b coll=%0d want 0/0 coll=0", d1_oob, d2_oob, d1_coll);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset_inflight();
        @(negedge clk); idle(); drive(1, 1, 0, 7, 4'h0, 32'h0); step();
        @(negedge clk); idle();
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (d2_s1_readdatavalid !== 1'b0 || d1_s1_readdatavalid !== 1'b0 || d1_s1_readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL inflight_async: got vld=%b/%b data=%h want 0/0 data=0", d1_s1_readdatavalid, d2_s1_readdatavalid, d1_s1_readdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 1, 0, 5, 4'h0, 32'h0);
        step();
        vectors++;
        if (d1_s1_readdatavalid !== 1'b1 || d1_s1_readdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL first_edge_read: got vld=%b data=%h want vld=1 data=deadbeef", d1_s1_readdatavalid, d1_s1_readdata);
        end
        vectors++;
        if (d2_s1_readdatavalid !== 1'b0) begin
            miscompares++; $display("FAIL inflight_discard: got vld=%b want 0", d2_s1_readdatavalid);
        end
        @(negedge clk); idle(); step();
        vectors++;
        if (d2_s1_readdatavalid !== 1'b1 || d2_s1_readdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL post_reset_lat2: got vld=%b data=%h want vld=1 data=deadbeef", d2_s1_readdatavalid, d2_s1_readdata);
        end
        @(negedge clk); idle(); step();
        vectors++;
        if (d2_s1_readdatavalid !== 1'b0 || d1_s1_readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: got vld=%b/%b want 0/0", d1_s1_readdatavalid, d2_s1_readdatavalid);
        end
    endtask

    task automatic test_stall_lat2();
        logic [DW-1:0] v [4];
        logic [DW-1:0] beats [4];
        int  nbeats = 0;
        int  ra [7] = '{0, 1, 2, 2, 3, 0, 0};
        bit  rv [7] = '{1, 1, 1, 1, 1, 0, 0};
        bit  ce [7] = '{1, 1, 0, 1, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            v[i] = $urandom;
            @(negedge clk); idle(); drive(1, 0, 1, i, 4'hF, v[i]); step();
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); idle();
            if (rv[i]) drive(1, 1, 0, ra[i], 4'h0, 32'h0);
            s1_clken = ce[i];
            step();
            if (i == 2) begin
                vectors++;
                if (d2_s1_readdatavalid !== 1'b0) begin
                    miscompares++; $display("FAIL stall_vld: got %b want 0", d2_s1_readdatavalid);
                end
            end
            if (d2_s1_readdatavalid === 1'b1) begin
                if (nbeats < 4) beats[nbeats] = d2_s1_readdata;
                nbeats++;
            end
        end
        vectors++;
        if (nbeats != 4) begin
            miscompares++; $display("FAIL stall_beats: got %0d want 4", nbeats);
        end
        for (int i = 0; i < 4 && i < nbeats; i++) begin
            vectors++;
            if (beats[i] !== v[i]) begin
                miscompares++; $display("FAIL stall_order[%0d]: got %h want %h", i, beats[i], v[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk); idle(); drive(1, 0, 1, a, 4'hF, $urandom); step();
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            s1_chipselect = ($urandom_range(0, 3) != 0);
            s1_read       = 1'($urandom_range(0, 1));
            s1_write      = 1'($urandom_range(0, 1));
            s1_clken      = ($urandom_range(0, 4) != 0);
            s1_byteenable = 4'($urandom);
            s1_writedata  = $urandom;
            s1_address    = ($urandom_range(0, 19) == 0) ? AW'(DEPTH + $urandom_range(0, 50)) : AW'($urandom_range(0, 15));
            s2_chipselect = ($urandom_range(0, 3) != 0);
            s2_read       = 1'($urandom_range(0, 1));
            s2_write      = 1'($urandom_range(0, 1));
            s2_clken      = ($urandom_range(0, 4) != 0);
            s2_byteenable = 4'($urandom);
            s2_writedata  = $urandom;
            s2_address    = ($urandom_range(0, 3) == 0) ? s1_address : AW'($urandom_range(0, 15));
            step();
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (act_vld[k] !== exp_vld[k]) begin
                    miscompares++; $display("FAIL rand_vld[%0d] cyc %0d: got %b want %b", k, c, act_vld[k], exp_vld[k]);
                end
                if (!$isunknown(exp_data[k])) begin
                    vectors++;
                    if (act_data[k] !== exp_data[k]) begin
                        miscompares++; $display("FAIL rand_data[%0d] cyc %0d: got %h want %h", k, c, act_data[k], exp_data[k]);
                    end
                end
            end
            vectors++;
            if (d1_oob !== m_oob || d2_oob !== m_oob) begin
                miscompares++; $display("FAIL rand_oob cyc %0d: got %b/%b want %b", c, d1_oob, d2_oob, m_oob);
            end
            vectors++;
            if (d1_coll !== 16'(m_coll) || d2_coll !== 16'(m_coll)) begin
                miscompares++; $display("FAIL rand_coll cyc %0d: got %0d/%0d want %0d", c, d1_coll, d2_coll, m_coll);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_collision();
        test_oob();
        test_reset_inflight();
        test_stall_lat2();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qsys_design_onchip_ram_2port.md
QSYS_DESIGN_ONCHIP_RAM_2PORT -- requirements
Module: qsys_design_onchip_ram_2port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 14: address width in words.
REQ-003 The block SHALL have parameter DEPTH, default 10120: number of words, 1..2^ADDR_WIDTH, not required to be a power of two.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1: cycles from read accept to data, legal values 1 or 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have, for N in {1,2}, port sN_address, input, ADDR_WIDTH bits: word address.
REQ-008 The block SHALL have, for N in {1,2}, ports sN_chipselect, sN_read, sN_write and sN_clken, each input, 1 bit: select, read strobe, write strobe and port clock enable.
REQ-009 The block SHALL have, for N in {1,2}, port sN_byteenable, input, DATA_WIDTH/8 bits: byte lane enables.
REQ-010 The block SHALL have, for N in {1,2}, port sN_writedata, input, DATA_WIDTH bits: write data.
REQ-011 The block SHALL have, for N in {1,2}, port sN_readdata, output, DATA_WIDTH bits: read data.
REQ-012 The block SHALL have, for N in {1,2}, port sN_readdatavalid, output, 1 bit: one-cycle read data qualifier.
REQ-013 The block SHALL have port oob_err, output, 1 bit: sticky out-of-range access flag.
REQ-014 The block SHALL have port collision_count, output, 16 bits: saturating count of same-address dual writes.

Function
REQ-015 Storage SHALL be DEPTH words of DATA_WIDTH; both ports SHALL be fully independent read/write ports.
REQ-016 A port access SHALL be accepted only on an edge where sN_chipselect=1 and sN_clken=1.
REQ-017 On an accepted write with address<DEPTH, exactly the byte lanes with sN_byteenable=1 SHALL be updated; other lanes unchanged.
REQ-018 If sN_read and sN_write are both 1 on an accepted edge, the write SHALL execute and the read SHALL be dropped (no readdatavalid).
REQ-019 An accepted read SHALL return data with sN_readdatavalid=1 for exactly one cycle, READ_LATENCY accepting-enabled edges later; reads are fully pipelined, one per cycle.
REQ-020 The per-port read pipeline SHALL advance only on edges with sN_clken=1; with sN_clken=0 it holds, sN_readdata holds, and sN_readdatavalid SHALL be 0.
REQ-021 sN_readdata SHALL hold its last value between valid beats.
REQ-022 A read of an address written in the same cycle (either port) SHALL return the old data (read-before-write).
REQ-023 If both ports write the same in-range address on the same edge, byte lanes enabled on s1 SHALL take s1 data; lanes enabled only on s2 SHALL take s2 data; collision_count SHALL increment by 1, saturating at 16'hFFFF.
REQ-024 An accepted access with address>=DEPTH SHALL set oob_err; such writes SHALL be ignored; such reads SHALL still complete with readdata=0 and readdatavalid=1.
REQ-025 oob_err SHALL remain 1 until reset_n is asserted.
REQ-026 With READ_LATENCY=2, the first stage SHALL register array output and the second stage SHALL register sN_readdata.

Reset
REQ-027 On reset_n=0, asynchronously: sN_readdatavalid=0, sN_readdata=0, all read pipeline valid bits=0, oob_err=0, collision_count=0.
REQ-028 Memory contents SHALL NOT be cleared by reset; reads in flight at reset SHALL be discarded with no readdatavalid after release.
REQ-029 The first access SHALL be accepted on the first rising edge with reset_n=1.

Verification
REQ-030 The bench SHALL cover: s1 writes 32'hDEADBEEF to addr 5, be=4'hF; s2 reads addr 5, READ_LATENCY=1 -> s2_readdata=32'hDEADBEEF with s2_readdatavalid=1 one cycle after accept.
REQ-031 The bench SHALL cover: addr 7 holds 32'h11223344; s1 writes 32'hAABBCCDD, be=4'b0101 -> subsequent read returns 32'h11BB33DD.
REQ-032 The bench SHALL cover: same edge, s1 writes 32'h000000AA be=4'b0001 and s2 writes 32'hBBBBBBBB be=4'b0011 to addr 9 (prior 0) -> addr 9 reads 32'h0000BBAA; collision_count=1.
REQ-033 The bench SHALL cover: s1 reads addr 10120 -> readdata=0, readdatavalid=1, oob_err=1; oob_err stays 1 until reset_n pulse, then 0.
REQ-034 The bench SHALL cover: READ_LATENCY=2, back-to-back reads of addr 0..3 with s1_clken=0 for one cycle mid-burst -> four valid beats in order, readdatavalid low during the stalled cycle.
REQ-035 The bench SHALL cover: reset_n asserted one cycle after a read accept -> no readdatavalid after release; previously written data still readable.
